// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch-stage types and constants
package fetch_unit_pkg;
  typedef enum logic [1:0] {REQ, WAIT, FLUSH} fetch_state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        misaligned;
  } fetch_entry_t;
  localparam int INST_BYTES = 4;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries; a push during flush lands in the freshly emptied buffer
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic pop_fire;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign pop_fire = pop && !empty;
  assign dout = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk) if (push) mem[flush ? '0 : wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= AW'(push);
      rd_ptr <= '0;
      count <= (AW+1)'(push);
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop_fire);
      count <= count + (AW+1)'(push) - (AW+1)'(pop_fire);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch, one outstanding imem request, decode FIFO; FETCH_MISALIGN_TRAP_EN turns misaligned redirects into marker entries
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        inst_misaligned
);
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_t state;
  logic [31:0] fetch_pc, target;
  logic live, stall, trap, fire, pending, push, pop, full, empty;
  logic [CW-1:0] count;
  fetch_entry_t din, head;
  assign target = TRAP_EN ? redirect_pc : redirect_pc & ~32'd3;
  assign trap = TRAP_EN && redirect_valid && redirect_pc[1:0] != 2'b00;
  // in REQ nothing is outstanding, so occupancy alone carries the credit
  assign imem_req_valid = live && !stall && state == REQ && int'(count) < FIFO_DEPTH;
  assign imem_req_addr = fetch_pc;
  assign fire = imem_req_valid && imem_req_ready;
  assign pending = fire || (state != REQ && !imem_rsp_valid);
  assign push = redirect_valid ? trap : state == WAIT && imem_rsp_valid;
  assign pop = inst_valid && inst_ready && !redirect_valid;
  assign din = '{pc: trap ? redirect_pc : fetch_pc, inst: trap ? 32'd0 : imem_rsp_data, misaligned: trap};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= REQ;
      fetch_pc <= RESET_PC;
      live <= 1'b0;
      stall <= 1'b0;
    end else begin
      live <= 1'b1;
      if (redirect_valid) begin
        state <= pending ? FLUSH : REQ;
        fetch_pc <= target;
        stall <= trap;
      end else if (state == REQ) begin
        state <= fire ? WAIT : REQ;
      end else if (imem_rsp_valid) begin
        state <= REQ;
        fetch_pc <= state == WAIT ? fetch_pc + 32'(INST_BYTES) : fetch_pc;
      end
    end
  end
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(redirect_valid),
    .din(din), .dout(head), .full(full), .empty(empty), .count(count)
  );
  assign inst_valid = !empty;
  assign inst_data = head.inst;
  assign inst_pc = head.pc;
  assign inst_misaligned = TRAP_EN && head.misaligned;
  no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop && !redirect_valid));
endmodule
